// File: rtl/elm_layer_sequencer.sv
// rtl/elm_layer_sequencer.sv - ELM hidden-layer sequencer: buffer, broadcast, collect, drain
//
// Collects NUM_IN samples from the upstream stream, replays them to all
// neurons as one gap-free burst, captures every neuron's activation on its
// outvalid pulse, then drains the results one neuron per beat.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   s_data/s_valid/s_ready   upstream sample stream (accepted only in LOAD)
//   nrn_in/nrn_in_valid      registered broadcast to all neurons
//   nrn_outvalid/nrn_out     per-neuron result pulse and packed activations
//   m_data/m_valid/m_ready   downstream result stream, m_last on final neuron
//   busy                     high while STREAM, WAIT or DRAIN
//   err_timeout              sticky: a neuron failed to answer within TIMEOUT
//
// NUM_IN and NUM_NEURON must both be at least 2.

module elm_layer_sequencer #(
    parameter int NUM_IN     = 128,
    parameter int NUM_NEURON = 8,
    parameter int DATA_W     = 16,
    parameter int OUT_W      = 8,
    parameter int TIMEOUT    = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DATA_W-1:0]           s_data,
    input  logic                        s_valid,
    output logic                        s_ready,
    output logic [DATA_W-1:0]           nrn_in,
    output logic                        nrn_in_valid,
    input  logic [NUM_NEURON-1:0]       nrn_outvalid,
    input  logic [NUM_NEURON*OUT_W-1:0] nrn_out,
    output logic [OUT_W-1:0]            m_data,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic                        m_last,
    output logic                        busy,
    output logic                        err_timeout
);

    localparam int CW_IN  = $clog2(NUM_IN) + 1;
    localparam int IW_IN  = $clog2(NUM_IN);
    localparam int CW_NRN = $clog2(NUM_NEURON) + 1;
    localparam int IW_NRN = $clog2(NUM_NEURON);
    localparam int CW_TO  = $clog2(TIMEOUT) + 1;

    localparam logic [CW_IN-1:0]  IN_LAST  = CW_IN'(NUM_IN - 1);
    localparam logic [CW_IN-1:0]  IN_END   = CW_IN'(NUM_IN);
    localparam logic [CW_NRN-1:0] NRN_LAST = CW_NRN'(NUM_NEURON - 1);
    localparam logic [CW_TO-1:0]  TO_LAST  = CW_TO'(TIMEOUT - 1);

    typedef enum logic [1:0] {ST_LOAD, ST_STREAM, ST_WAIT, ST_DRAIN} state_t;

    state_t state, state_next;

    logic [CW_IN-1:0]  wcnt;
    logic [CW_IN-1:0]  rcnt;
    logic [CW_NRN-1:0] ocnt;
    logic [CW_TO-1:0]  tcnt;
    logic [NUM_NEURON-1:0] done, done_next;
    logic [DATA_W-1:0] sample_buf [NUM_IN];
    logic [OUT_W-1:0]  res_buf [NUM_NEURON];

    logic last_in_accept, stream_end, all_done, timeout_hit, last_beat;

    // done_next folds in this cycle's pulses so completion is seen the same
    // cycle the final capture happens.
    always_comb begin
        done_next = done;
        if (state == ST_WAIT) begin
            done_next = done | nrn_outvalid;
        end
        all_done       = &done_next;
        last_in_accept = (state == ST_LOAD) && s_valid && (wcnt == IN_LAST);
        stream_end     = (state == ST_STREAM) && (rcnt == IN_END);
        timeout_hit    = (state == ST_WAIT) && !all_done && (tcnt == TO_LAST);
        last_beat      = (state == ST_DRAIN) && m_ready && (ocnt == NRN_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_LOAD;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_LOAD:   if (last_in_accept) state_next = ST_STREAM;
            ST_STREAM: if (stream_end)     state_next = ST_WAIT;
            ST_WAIT: begin
                if (all_done)         state_next = ST_DRAIN;
                else if (timeout_hit) state_next = ST_LOAD;
            end
            ST_DRAIN:  if (last_beat)      state_next = ST_LOAD;
            default:                       state_next = ST_LOAD;
        endcase
    end

    always_comb begin
        s_ready = (state == ST_LOAD);
        busy    = (state != ST_LOAD);
        m_valid = (state == ST_DRAIN);
        m_last  = (state == ST_DRAIN) && (ocnt == NRN_LAST);
        m_data  = '0;
        if (state == ST_DRAIN) begin
            m_data = res_buf[ocnt[IW_NRN-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt         <= '0;
            rcnt         <= '0;
            ocnt         <= '0;
            tcnt         <= '0;
            done         <= '0;
            nrn_in       <= '0;
            nrn_in_valid <= 1'b0;
            err_timeout  <= 1'b0;
            for (int i = 0; i < NUM_IN; i++) sample_buf[i] <= '0;
            for (int i = 0; i < NUM_NEURON; i++) res_buf[i] <= '0;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (s_valid) begin
                        sample_buf[wcnt[IW_IN-1:0]] <= s_data;
                        if (last_in_accept) begin
                            // Preload beat 0 so the burst starts in the
                            // first STREAM cycle.
                            wcnt         <= '0;
                            nrn_in       <= sample_buf[0];
                            nrn_in_valid <= 1'b1;
                            rcnt         <= CW_IN'(1);
                        end else begin
                            wcnt <= wcnt + 1'b1;
                        end
                    end
                end
                ST_STREAM: begin
                    if (stream_end) begin
                        // nrn_in keeps the last sample; only valid falls.
                        nrn_in_valid <= 1'b0;
                        done         <= '0;
                        tcnt         <= '0;
                    end else begin
                        nrn_in <= sample_buf[rcnt[IW_IN-1:0]];
                        rcnt   <= rcnt + 1'b1;
                    end
                end
                ST_WAIT: begin
                    done <= done_next;
                    tcnt <= tcnt + 1'b1;
                    ocnt <= '0;
                    for (int i = 0; i < NUM_NEURON; i++) begin
                        if (nrn_outvalid[i] && !done[i]) begin
                            res_buf[i] <= nrn_out[i*OUT_W +: OUT_W];
                        end
                    end
                    if (timeout_hit) begin
                        err_timeout <= 1'b1;
                        done        <= '0;
                        for (int i = 0; i < NUM_NEURON; i++) res_buf[i] <= '0;
                    end
                end
                ST_DRAIN: begin
                    if (m_ready) begin
                        if (last_beat) begin
                            ocnt <= '0;
                            done <= '0;
                        end else begin
                            ocnt <= ocnt + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_elm_layer_sequencer.sv
// tb/tb_elm_layer_sequencer.sv - scoreboard bench for elm_layer_sequencer

module tb_elm_layer_sequencer;

    localparam int NUM_IN     = 4;
    localparam int NUM_NEURON = 2;
    localparam int DATA_W     = 16;
    localparam int OUT_W      = 8;
    localparam int TIMEOUT    = 8;

    logic                        clk = 1'b0;
    logic                        rst = 1'b1;
    logic [DATA_W-1:0]           s_data = '0;
    logic                        s_valid = 1'b0;
    logic                        s_ready;
    logic [DATA_W-1:0]           nrn_in;
    logic                        nrn_in_valid;
    logic [NUM_NEURON-1:0]       nrn_outvalid = '0;
    logic [NUM_NEURON*OUT_W-1:0] nrn_out = '0;
    logic [OUT_W-1:0]            m_data;
    logic                        m_valid;
    logic                        m_ready = 1'b0;
    logic                        m_last;
    logic                        busy;
    logic                        err_timeout;

    int vectors = 0;
    int miscompares = 0;

    logic [DATA_W-1:0] exp_in_q [$];
    logic [OUT_W:0]    exp_m_q [$];   // {last, data}

    elm_layer_sequencer #(
        .NUM_IN(NUM_IN), .NUM_NEURON(NUM_NEURON), .DATA_W(DATA_W),
        .OUT_W(OUT_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .nrn_in(nrn_in), .nrn_in_valid(nrn_in_valid),
        .nrn_outvalid(nrn_outvalid), .nrn_out(nrn_out),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
        .busy(busy), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard on every broadcast beat and every accepted
    // result beat; also checks burst length and stall stability.
    int  run_len = 0;
    bit  run_aborted = 1'b0;
    logic [OUT_W:0] front;
    always @(negedge clk) begin
        if (nrn_in_valid) begin
            if (exp_in_q.size() == 0) check("nrn_in_unexpected", 32'(nrn_in), 32'hFFFF_FFFF);
            else check("nrn_in_data", 32'(nrn_in), 32'(exp_in_q.pop_front()));
            run_len++;
            if (rst) run_aborted = 1'b1;
        end else if (run_len != 0) begin
            if (!run_aborted) check("burst_len", run_len, NUM_IN);
            run_len = 0;
            run_aborted = 1'b0;
        end
        if (m_valid) begin
            if (exp_m_q.size() == 0) begin
                check("m_unexpected", {23'd0, m_last, m_data}, 32'hFFFF_FFFF);
            end else if (m_ready) begin
                front = exp_m_q.pop_front();
                check("m_beat", {23'd0, m_last, m_data}, {23'd0, front});
            end else begin
                front = exp_m_q[0];
                check("m_stall_hold", {23'd0, m_last, m_data}, {23'd0, front});
            end
        end
    end

    task automatic send_vec(input int base, input bit toggle, input int npush);
        for (int k = 0; k < npush; k++) exp_in_q.push_back(DATA_W'(base + k));
        for (int k = 0; k < NUM_IN; k++) begin
            s_data  = DATA_W'(base + k);
            s_valid = 1'b1;
            tick();
            if (toggle && k < NUM_IN - 1) begin
                s_valid = 1'b0;
                s_data  = 16'hDEAD;
                tick();
            end
        end
        s_valid = 1'b0;
        check("s_ready_drop", 32'(s_ready), 0);
        check("first_beat_valid", 32'(nrn_in_valid), 1);
    endtask

    task automatic wait_stream_end();
        int n = 0;
        while (nrn_in_valid && n < 20) begin tick(); n++; end
        check("stream_end_bound", 32'(n < 20), 1);
    endtask

    task automatic wait_load();
        int n = 0;
        while (!s_ready && n < 20) begin tick(); n++; end
        check("return_load_bound", 32'(n < 20), 1);
    endtask

    task automatic pulse(input logic [NUM_NEURON-1:0] mask, input logic [NUM_NEURON*OUT_W-1:0] data);
        nrn_outvalid = mask;
        nrn_out      = data;
        tick();
        nrn_outvalid = '0;
        nrn_out      = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        // Reset state
        repeat (3) tick();
        rst = 1'b0;
        check("rst_s_ready", 32'(s_ready), 1);
        check("rst_nrn_in", 32'(nrn_in), 0);
        check("rst_nrn_in_valid", 32'(nrn_in_valid), 0);
        check("rst_m_valid", 32'(m_valid), 0);
        check("rst_m_last", 32'(m_last), 0);
        check("rst_m_data", 32'(m_data), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_err", 32'(err_timeout), 0);

        // 1: continuous load, simultaneous capture, free-running drain
        send_vec(1, 1'b0, 4);
        check("busy_stream", 32'(busy), 1);
        wait_stream_end();
        check("wait_nrn_in_hold", 32'(nrn_in), 4);
        check("wait_no_m_valid", 32'(m_valid), 0);
        m_ready = 1'b1;
        exp_m_q.push_back({1'b0, 8'h3C});
        exp_m_q.push_back({1'b1, 8'hA5});
        pulse(2'b11, {8'hA5, 8'h3C});
        check("m_valid_latency", 32'(m_valid), 1);
        wait_load();
        check("t1_busy_after", 32'(busy), 0);
        check("t1_m_valid_after", 32'(m_valid), 0);

        // 2+4: toggled load, staggered pulses with a repeat, stalled drain
        m_ready = 1'b0;
        send_vec(1, 1'b1, 4);
        wait_stream_end();
        exp_m_q.push_back({1'b0, 8'h3C});
        exp_m_q.push_back({1'b1, 8'hA5});
        tick(); tick();
        pulse(2'b01, {8'h77, 8'h3C});
        pulse(2'b01, {8'h00, 8'hFF});
        tick();
        check("no_m_valid_before_2nd", 32'(m_valid), 0);
        pulse(2'b10, {8'hA5, 8'h11});
        check("m_valid_after_2nd", 32'(m_valid), 1);
        for (int i = 0; i < 3; i++) begin
            check("stall_m_data", 32'(m_data), 32'h3C);
            check("stall_m_last", 32'(m_last), 0);
            tick();
        end
        m_ready = 1'b1;
        wait_load();
        check("t4_err_clear", 32'(err_timeout), 0);

        // 5: only neuron 1 answers -> timeout after TIMEOUT wait cycles
        send_vec(9, 1'b0, 4);
        wait_stream_end();
        pulse(2'b10, {8'h55, 8'h00});
        n = 1;
        while (!s_ready && n < 40) begin tick(); n++; end
        check("timeout_cycles", n, TIMEOUT);
        check("timeout_err", 32'(err_timeout), 1);
        check("timeout_busy", 32'(busy), 0);
        repeat (3) tick();
        check("timeout_err_sticky", 32'(err_timeout), 1);

        // 6: reset during second STREAM beat, then a fresh vector
        send_vec(16'h11, 1'b0, 2);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_valid", 32'(nrn_in_valid), 0);
        check("rst_mid_s_ready", 32'(s_ready), 1);
        check("rst_mid_busy", 32'(busy), 0);
        check("rst_mid_err", 32'(err_timeout), 0);
        send_vec(1, 1'b0, 4);
        wait_stream_end();
        exp_m_q.push_back({1'b0, 8'hC3});
        exp_m_q.push_back({1'b1, 8'h5A});
        pulse(2'b11, {8'h5A, 8'hC3});
        wait_load();

        repeat (3) tick();
        check("in_queue_empty", exp_in_q.size(), 0);
        check("m_queue_empty", exp_m_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
